// File: rtl/sdram_test_pkg.sv
// Shared constants for the SDRAM memory-test reporter: ASCII codes, FSM states
// and line geometry derived from the reported address/data widths.
package sdram_test_pkg;

  localparam logic [7:0] CHAR_P  = 8'h50;
  localparam logic [7:0] CHAR_F  = 8'h46;
  localparam logic [7:0] CHAR_SP = 8'h20;
  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_LF = 8'h0A;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAITRDY = 2'd1,
    GUARD   = 2'd2
  } state_t;

  function automatic int addr_digits(input int addr_w);
    return (addr_w + 3) / 4;
  endfunction

  // status, space, address digits, space, data digits, CR, LF
  function automatic int line_len(input int addr_w, input int data_w);
    return addr_digits(addr_w) + data_w / 4 + 5;
  endfunction

  localparam int DEF_ADDR_W = 23;
  localparam int DEF_DATA_W = 32;
  localparam int LINE_LEN   = line_len(DEF_ADDR_W, DEF_DATA_W);
  localparam int LAST       = LINE_LEN - 1;

endpackage

// File: rtl/hex_nibble_ascii.sv
// Converts one 4-bit nibble to its uppercase ASCII hex digit.
module hex_nibble_ascii (
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  always_comb begin
    if (nibble < 4'd10) ascii = 8'h30 + {4'h0, nibble};
    else                ascii = 8'h37 + {4'h0, nibble};
  end

endmodule

// File: rtl/sdram_test_reporter.sv
// Formats SDRAM test result events as fixed-length ASCII lines and feeds them
// one byte at a time to the uart transmitter.
module sdram_test_reporter
  import sdram_test_pkg::*;
#(
  parameter int ADDR_W = 23,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              report_valid,
  output logic              report_ready,
  input  logic              report_fail,
  input  logic [ADDR_W-1:0] report_addr,
  input  logic [DATA_W-1:0] report_data,
  output logic [7:0]        tx_byte,
  output logic              tx_en,
  input  logic              tx_ready,
  output logic              busy,
  output logic [15:0]       line_count
);

  localparam int ADDR_DIGITS = addr_digits(ADDR_W);
  localparam int DATA_DIGITS = DATA_W / 4;
  localparam int LEN         = line_len(ADDR_W, DATA_W);
  localparam int LAST_IDX    = LEN - 1;
  localparam int IDX_W       = $clog2(LEN);
  localparam int ADDR_EXT_W  = ADDR_DIGITS * 4;
  localparam int ADDR_FIRST  = 2;
  localparam int DATA_FIRST  = ADDR_FIRST + ADDR_DIGITS + 1;

  state_t            state;
  logic [IDX_W-1:0]  idx;
  logic              fail_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [ADDR_EXT_W-1:0] addr_ext;

  int                pos;
  logic [3:0]        nibble;
  logic              use_hex;
  logic [7:0]        fixed_char;
  logic [7:0]        hex_char;
  logic [7:0]        char_cur;

  assign addr_ext     = ADDR_EXT_W'(addr_q);
  assign report_ready = (state == IDLE);
  assign busy         = (state != IDLE);

  // Character at the current line position; hex digits go MSB first.
  always_comb begin
    pos        = int'(idx);
    nibble     = 4'h0;
    use_hex    = 1'b0;
    fixed_char = CHAR_SP;
    if (pos == 0) fixed_char = report_fail_char(fail_q);
    else if (pos == LAST_IDX - 1) fixed_char = CHAR_CR;
    else if (pos == LAST_IDX) fixed_char = CHAR_LF;
    for (int d = 0; d < ADDR_DIGITS; d++) begin
      if (pos == ADDR_FIRST + ADDR_DIGITS - 1 - d) begin
        use_hex = 1'b1;
        nibble  = addr_ext[d*4 +: 4];
      end
    end
    for (int d = 0; d < DATA_DIGITS; d++) begin
      if (pos == DATA_FIRST + DATA_DIGITS - 1 - d) begin
        use_hex = 1'b1;
        nibble  = data_q[d*4 +: 4];
      end
    end
  end

  function automatic logic [7:0] report_fail_char(input logic f);
    return f ? CHAR_F : CHAR_P;
  endfunction

  hex_nibble_ascii u_hex (
    .nibble (nibble),
    .ascii  (hex_char)
  );

  assign char_cur = use_hex ? hex_char : fixed_char;

  // GUARD ignores tx_ready so the uart has a cycle to drop it after a strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      idx        <= '0;
      tx_en      <= 1'b0;
      tx_byte    <= 8'h00;
      line_count <= 16'h0000;
      fail_q     <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          tx_en <= 1'b0;
          if (report_valid) begin
            fail_q <= report_fail;
            addr_q <= report_addr;
            data_q <= report_data;
            idx    <= '0;
            state  <= WAITRDY;
          end
        end
        WAITRDY: begin
          if (tx_ready) begin
            tx_byte <= char_cur;
            tx_en   <= 1'b1;
            state   <= GUARD;
          end else begin
            tx_en <= 1'b0;
          end
        end
        GUARD: begin
          tx_en <= 1'b0;
          if (idx == IDX_W'(LAST_IDX)) begin
            if (line_count != 16'hFFFF) line_count <= line_count + 16'd1;
            idx   <= '0;
            state <= IDLE;
          end else begin
            idx   <= idx + IDX_W'(1);
            state <= WAITRDY;
          end
        end
        default: begin
          tx_en <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/sdram_test_reporter.md
Name: sdram_test_reporter

Overview:
- Downstream consumer of the SDRAM memory-test sequencer's result events.
- Formats each result as a fixed-length ASCII line and streams it byte-by-byte into the existing uart block through its tx_byte/tx_en/tx_ready port.
- Lets the board report PASS/FAIL, failing address and read-back data over the serial pin, in place of LEDs.
- Runs in the clk100 domain, alongside the SDRAM controller and uart.

Parameters:
- ADDR_W, 23: width of the reported address. Printed as ceil(ADDR_W/4) hex digits, zero-extended.
- DATA_W, 32: width of the reported data word. Must be a multiple of 4. Printed as DATA_W/4 hex digits.

Ports:
- clk  input  1  system clock (clk100).
- rst  input  1  asynchronous, active-low reset.
- report_valid  input  1  result event available.
- report_ready  output  1  block can accept an event; high only in IDLE.
- report_fail  input  1  1 = fault line ('F'), 0 = pass line ('P').
- report_addr  input  ADDR_W  address associated with the event.
- report_data  input  DATA_W  data word (value read back).
- tx_byte  output  8  byte to uart.
- tx_en  output  1  one-cycle strobe to uart.
- tx_ready  input  1  uart can accept a byte.
- busy  output  1  high while a line is being sent (state != IDLE).
- line_count  output  16  completed lines; saturates at 0xFFFF.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-low.
- Reset values: state=IDLE, tx_en=0, tx_byte=0x00, line_count=0, char index=0, capture registers=0.
  - report_ready is decoded from state, so it is 1 as soon as reset is applied. busy=0.
- Line format (defaults give 19 bytes), sent MSB digit first:
  - status char ('P' 0x50 / 'F' 0x46)
  - ' ' 0x20
  - 6 address hex digits
  - ' ' 0x20
  - 8 data hex digits
  - CR 0x0D, LF 0x0A
- Hex mapping: nibble 0-9 -> 0x30+n; nibble 10-15 -> 0x41+(n-10). Digits are uppercase.
- Acceptance: on a clk edge with report_valid && report_ready, the block latches fail/addr/data, sets index=0 and moves to WAITRDY.
  - Inputs are ignored outside IDLE.
  - report_valid may stay high across lines; the next event is accepted only once back in IDLE.
- FSM:
  - IDLE: report_ready=1; on accept -> WAITRDY.
  - WAITRDY: if tx_ready, register tx_byte=char[index] and tx_en=1, go GUARD; otherwise hold with tx_en=0.
  - GUARD: tx_en<=0, index<=index+1.
    - If index was LAST (18), line_count++ (saturating) and go IDLE.
    - Otherwise go WAITRDY.
- tx_ready is not sampled in GUARD. This gives uart one cycle to drop tx_ready after a strobe.
- tx_en is high for exactly one cycle per byte. tx_byte is stable while tx_en is high and holds its value afterwards.
- Throughput: with tx_ready held high, one byte every 2 cycles.
  - First tx_en is high in the 2nd cycle after the accept edge.
  - A full line takes 38 cycles to the return to IDLE.
- Back-to-back: a new line can be accepted the cycle after the return to IDLE. There is no partial-line interleave.
- Reset mid-line: the async reset forces tx_en=0 immediately and aborts the line; no CR/LF is sent. The next accepted event starts at index 0.
- Wrap: the index never exceeds LAST. line_count does not wrap.

Decomposition:
- Shared package/include (sdram_test_pkg), which holds:
  - ASCII constants: CHAR_P, CHAR_F, CHAR_SP, CHAR_CR, CHAR_LF.
  - FSM state encodings: IDLE, WAITRDY, GUARD.
  - LINE_LEN and LAST index derived from ADDR_W/DATA_W.
- One sub-module, hex_nibble_ascii: a 4-bit -> 8-bit combinational converter, instantiated once on the nibble selected by the index mux.

Test Plan:
- PASS, tx_ready always 1: accept fail=0, addr=0x000000, data=0x0000AAAA.
  - Required: 19 strobes carrying "P 000000 0000AAAA\r\n"; strobes 2 cycles apart; line_count=1.
- FAIL, max address: accept fail=1, addr=0x7FFFFF, data=0xDEADBEEF.
  - Required: "F 7FFFFF DEADBEEF\r\n" with uppercase hex.
- Slow uart model: tx_ready drops the cycle after each strobe and returns 10 cycles later.
  - Required: no tx_en while tx_ready=0; exactly 19 strobes; no duplicate bytes.
- Back-to-back: report_valid held high with 2 events.
  - Required: report_ready=0 from accept until the cycle after the LF strobe; second line starts only after that; line_count=2.
- Reset mid-line: assert rst low after the 5th strobe.
  - Required: tx_en=0 and busy=0 in the same cycle; line_count=0.
  - After release, the next event produces a complete line starting with its status char.
- Saturation: force 65536 lines (or preload via a bench-only force).
  - Required: line_count stays at 0xFFFF.
